// File: rtl/rand_delay_pkg.sv
// Shared constants, types and helpers for the valid-tagged variable-delay line.
package rand_delay_pkg;

  localparam int unsigned LP_DELAY_W = 8;
  localparam int unsigned LP_LFSR_W  = 16;

  // LFSR state after reset and the value substituted for an all-zero seed.
  localparam logic [LP_LFSR_W-1:0] LP_LFSR_RESET = 16'hACE1;
  localparam logic [LP_LFSR_W-1:0] LP_LFSR_NONZERO = 16'h0001;

  // Feedback mask for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10).
  localparam logic [LP_LFSR_W-1:0] LP_LFSR_TAPS = 16'hB400;

  // Where the requested tap comes from.
  typedef enum logic {
    TAP_FIXED = 1'b0,
    TAP_LFSR  = 1'b1
  } tap_src_e;

  // Limit a raw tap request to the last stage of a line of 'depth' stages.
  function automatic logic [LP_DELAY_W-1:0] clamp_tap(
    input logic [LP_DELAY_W-1:0] raw,
    input int unsigned           depth
  );
    logic [LP_DELAY_W-1:0] max_tap;
    max_tap = LP_DELAY_W'(depth - 1);
    return (raw > max_tap) ? max_tap : raw;
  endfunction

  // One left shift of the Fibonacci LFSR with the parity feedback into bit 0.
  function automatic logic [LP_LFSR_W-1:0] lfsr_step(input logic [LP_LFSR_W-1:0] cur);
    return {cur[LP_LFSR_W-2:0], ^(cur & LP_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rand_delay_vr_if.sv
// Valid-tagged data path into and out of the delay line.
interface rand_delay_vr_if #(
  parameter int unsigned P_WIDTH  = 8,
  parameter int unsigned P_NUM_CH = 2
);

  localparam int unsigned LP_DW = P_WIDTH * P_NUM_CH;

  logic             i_valid;
  logic [LP_DW-1:0] i_data;
  logic             o_valid;
  logic [LP_DW-1:0] o_data;

  // Producer/consumer side driving words into the line and watching the tap.
  modport master (
    output i_valid,
    output i_data,
    input  o_valid,
    input  o_data
  );

  // The delay line itself.
  modport slave (
    input  i_valid,
    input  i_data,
    output o_valid,
    output o_data
  );

endinterface

// File: rtl/rand_delay_lfsr16.sv
// 16-bit pseudo-random tap source with seed load; advances only when asked.
module rand_delay_lfsr16
  import rand_delay_pkg::*;
(
  input  logic                  clk_core,
  input  logic                  rst_x,
  input  logic                  seed_load,
  input  logic [LP_LFSR_W-1:0]  seed,
  input  logic                  advance,
  output logic [LP_DELAY_W-1:0] rnd
);

  logic [LP_LFSR_W-1:0] value_q;
  logic [LP_LFSR_W-1:0] value_d;

  // Next state: seed load wins over advance; a zero seed would lock up, so substitute 1.
  always_comb begin
    value_d = value_q;
    if (seed_load) begin
      value_d = (seed == '0) ? LP_LFSR_NONZERO : seed;
    end else if (advance) begin
      value_d = lfsr_step(value_q);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      value_q <= LP_LFSR_RESET;
    end else begin
      value_q <= value_d;
    end
  end

  assign rnd = value_q[LP_DELAY_W-1:0];

endmodule

// File: rtl/rand_delay_vr.sv
// Multi-lane valid-tagged delay line with a shared tap that only changes while idle.
module rand_delay_vr
  import rand_delay_pkg::*;
#(
  parameter int unsigned P_WIDTH  = 8,
  parameter int unsigned P_NUM_CH = 2,
  parameter int unsigned P_DEPTH  = 16
) (
  input  logic                  clk_core,
  input  logic                  rst_x,
  input  logic                  i_en,
  input  logic                  i_flush,
  input  logic                  i_mode,
  input  logic [LP_DELAY_W-1:0] i_delay,
  input  logic                  i_seed_load,
  input  logic [LP_LFSR_W-1:0]  i_seed,
  rand_delay_vr_if.slave        bus,
  output logic [LP_DELAY_W-1:0] o_delay,
  output logic                  o_busy
);

  localparam int unsigned LP_DW    = P_WIDTH * P_NUM_CH;
  localparam int unsigned LP_IDX_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  // Stage storage: data per stage plus one valid bit per stage.
  logic [LP_DW-1:0]      data_q [P_DEPTH];
  logic [P_DEPTH-1:0]    vld_q;
  logic [P_DEPTH-1:0]    vld_d;

  // Tap and occupancy state.
  logic [LP_DELAY_W-1:0] tap_q;
  logic [LP_DELAY_W-1:0] tap_d;
  logic                  busy_q;
  logic                  busy_d;

  // Tap control signals.
  tap_src_e              src_c;
  logic                  capture_c;
  logic                  tap_load_c;
  logic                  lfsr_adv_c;
  logic [LP_DELAY_W-1:0] req_c;
  logic [LP_DELAY_W-1:0] rnd;
  logic [LP_IDX_W-1:0]   tap_idx_c;

  rand_delay_lfsr16 u_lfsr (
    .clk_core  (clk_core),
    .rst_x     (rst_x),
    .seed_load (i_seed_load),
    .seed      (i_seed),
    .advance   (lfsr_adv_c),
    .rnd       (rnd)
  );

  // Tap request and load decision: reload only when no valid word is in flight
  // and none is entering this edge; flush overrides the in-flight check.
  always_comb begin
    src_c      = tap_src_e'(i_mode);
    capture_c  = i_en & bus.i_valid;
    tap_load_c = !capture_c && (i_flush || !busy_q);
    req_c      = clamp_tap((src_c == TAP_LFSR) ? rnd : i_delay, P_DEPTH);
    lfsr_adv_c = tap_load_c && (src_c == TAP_LFSR);
    tap_d      = tap_load_c ? req_c : tap_q;
  end

  // Valid-bit next state: shift on enable, flush clears all but a same-edge capture.
  always_comb begin
    vld_d = vld_q;
    if (i_en) begin
      vld_d = {vld_q[P_DEPTH-2:0], bus.i_valid};
    end
    if (i_flush) begin
      vld_d = '0;
      if (i_en) begin
        vld_d[0] = bus.i_valid;
      end
    end
    busy_d = |vld_d;
  end

  // Control registers: valid bits, active tap and busy flag.
  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      vld_q  <= '0;
      tap_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      tap_q  <= tap_d;
      busy_q <= busy_d;
    end
  end

  // Data shift register; flush leaves data alone, only valid bits are cleared.
  always_ff @(posedge clk_core) begin
    if (!rst_x) begin
      for (int k = 0; k < P_DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else if (i_en) begin
      data_q[0] <= bus.i_data;
      for (int k = 1; k < P_DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
      end
    end
  end

  // Output mux at the active tap; data is driven even when the tap is not valid.
  always_comb begin
    tap_idx_c   = tap_q[LP_IDX_W-1:0];
    bus.o_valid = vld_q[tap_idx_c];
    bus.o_data  = data_q[tap_idx_c];
  end

  assign o_delay = tap_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_rand_delay_vr.sv
// Self-checking bench: vector table, directed corner sequences and a random run against a queue model.
module tb_rand_delay_vr;

  localparam int unsigned W     = 8;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = W * NCH;
  localparam int          DMAX  = 15;

  logic        clk_core = 1'b0;
  logic        rst_x;
  logic        i_en;
  logic        i_flush;
  logic        i_mode;
  logic [7:0]  i_delay;
  logic        i_seed_load;
  logic [15:0] i_seed;
  logic [7:0]  o_delay;
  logic        o_busy;

  always #5 clk_core = ~clk_core;

  rand_delay_vr_if #(.P_WIDTH(W), .P_NUM_CH(NCH)) bus_if ();

  rand_delay_vr #(.P_WIDTH(W), .P_NUM_CH(NCH), .P_DEPTH(DEPTH)) dut (
    .clk_core    (clk_core),
    .rst_x       (rst_x),
    .i_en        (i_en),
    .i_flush     (i_flush),
    .i_mode      (i_mode),
    .i_delay     (i_delay),
    .i_seed_load (i_seed_load),
    .i_seed      (i_seed),
    .bus         (bus_if),
    .o_delay     (o_delay),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a list of in-flight valid words tagged with their age in enabled edges.
  typedef struct {
    logic [DW-1:0] data;
    int            age;
  } word_t;

  word_t       inflight[$];
  int          m_tap  = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  bit          m_busy = 1'b0;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int ref_req(input logic [7:0] raw);
    return (int'(raw) > DMAX) ? DMAX : int'(raw);
  endfunction

  task automatic model_edge();
    word_t nq[$];
    bit    cap;
    bit    load;
    int    req;
    if (!rst_x) begin
      inflight.delete();
      m_tap  = 0;
      m_lfsr = 16'hACE1;
      m_busy = 1'b0;
      return;
    end
    cap  = i_en && bus_if.i_valid;
    load = !cap && (i_flush || !m_busy);
    req  = ref_req(i_mode ? m_lfsr[7:0] : i_delay);
    if (i_seed_load) m_lfsr = (i_seed == 16'h0) ? 16'h0001 : i_seed;
    else if (load && i_mode) m_lfsr = ref_step(m_lfsr);
    if (load) m_tap = req;
    if (i_flush) inflight.delete();
    if (i_en) begin
      foreach (inflight[i]) begin
        if (inflight[i].age + 1 < int'(DEPTH)) nq.push_back('{inflight[i].data, inflight[i].age + 1});
      end
      inflight = nq;
      if (bus_if.i_valid) inflight.push_back('{bus_if.i_data, 0});
    end
    m_busy = (inflight.size() != 0);
  endtask

  task automatic check_model();
    bit            ev;
    logic [DW-1:0] ed;
    ev = 1'b0;
    ed = '0;
    foreach (inflight[i]) begin
      if (inflight[i].age == m_tap) begin
        ev = 1'b1;
        ed = inflight[i].data;
      end
    end
    chk("model_valid", 32'(bus_if.o_valid), 32'(ev));
    chk("model_delay", 32'(o_delay), 32'(m_tap));
    chk("model_busy", 32'(o_busy), 32'(m_busy));
    if (ev) chk("model_data", 32'(bus_if.o_data), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk_core);
    model_edge();
    #1;
    cyc++;
    check_model();
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = d;
    tick();
    bus_if.i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 64 && o_busy; n++) tick();
    chk("idle_reached", 32'(o_busy), 32'(0));
  endtask

  // Directed fixed-delay table: one row per edge, inputs then expected outputs after the edge.
  typedef struct {
    logic          rst_x;
    logic          valid;
    logic [7:0]    delay;
    logic [DW-1:0] data;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_delay;
    logic          exp_busy;
    logic          chk_data;
  } vec_t;

  vec_t tbl[22];
  int   lfsr_exp[12] = '{1, 2, 4, 8, 15, 15, 15, 15, 0, 0, 0, 1};

  initial begin
    int          lat;
    bit          found;
    int          cap_cyc;
    logic [15:0] lfsr_peek;

    rst_x          = 1'b0;
    i_en           = 1'b0;
    i_flush        = 1'b0;
    i_mode         = 1'b0;
    i_delay        = 8'd0;
    i_seed_load    = 1'b0;
    i_seed         = 16'h0;
    bus_if.i_valid = 1'b0;
    bus_if.i_data  = '0;

    for (int r = 0; r < 22; r++) begin
      tbl[r] = '{rst_x: 1'b1, valid: 1'b0, delay: 8'd5, data: '0, exp_valid: 1'b0, exp_data: '0,
                 exp_delay: 8'd5, exp_busy: (r >= 2 && r <= 20), chk_data: 1'b0};
    end
    tbl[0].rst_x     = 1'b0;
    tbl[0].exp_delay = 8'd0;
    tbl[0].chk_data  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tbl[2+n].valid     = 1'b1;
      tbl[2+n].data      = {8'(8'h91 + n), 8'(8'h11 + n)};
      tbl[7+n].exp_valid = 1'b1;
      tbl[7+n].exp_data  = {8'(8'h91 + n), 8'(8'h11 + n)};
    end

    // Fixed delay 5: four back-to-back words, each exits five edges after capture.
    for (int r = 0; r < 22; r++) begin
      rst_x          = tbl[r].rst_x;
      i_en           = 1'b1;
      i_delay        = tbl[r].delay;
      bus_if.i_valid = tbl[r].valid;
      bus_if.i_data  = tbl[r].data;
      tick();
      chk($sformatf("tbl%0d_valid", r), 32'(bus_if.o_valid), 32'(tbl[r].exp_valid));
      chk($sformatf("tbl%0d_delay", r), 32'(o_delay), 32'(tbl[r].exp_delay));
      chk($sformatf("tbl%0d_busy", r), 32'(o_busy), 32'(tbl[r].exp_busy));
      if (tbl[r].exp_valid || tbl[r].chk_data)
        chk($sformatf("tbl%0d_data", r), 32'(bus_if.o_data), 32'(tbl[r].exp_data));
    end
    bus_if.i_valid = 1'b0;

    // Clamp: request 200 on an idle line gives tap 15 and latency 15.
    i_delay = 8'd200;
    tick();
    chk("clamp_delay", 32'(o_delay), 32'(15));
    send(16'hABCD);
    lat   = 0;
    found = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      tick();
      if (bus_if.o_valid) begin
        found = 1'b1;
        lat   = n;
      end
    end
    chk("clamp_latency", 32'(lat), 32'(15));
    chk("clamp_data", 32'(bus_if.o_data), 32'(16'hABCD));

    // Tap freeze: delay change while busy waits until the line drains.
    wait_idle();
    i_delay = 8'd3;
    tick();
    chk("freeze_delay3", 32'(o_delay), 32'(3));
    send(16'h0A01);
    cap_cyc = cyc;
    i_delay = 8'd7;
    send(16'h0A02);
    for (int n = 0; n < 40 && !bus_if.o_valid; n++) tick();
    chk("freeze_latency", 32'(cyc - cap_cyc), 32'(3));
    chk("freeze_data", 32'(bus_if.o_data), 32'(16'h0A01));
    chk("freeze_hold", 32'(o_delay), 32'(3));
    tick();
    chk("freeze_data2", 32'(bus_if.o_data), 32'(16'h0A02));
    for (int n = 0; n < 40 && o_busy; n++) tick();
    chk("freeze_busy_fell", 32'(o_busy), 32'(0));
    chk("freeze_delay_at_fall", 32'(o_delay), 32'(3));
    tick();
    chk("freeze_delay7", 32'(o_delay), 32'(7));

    // Stall with a word sitting at the tap: outputs hold, nothing is lost.
    send(16'hB001);
    send(16'hB002);
    send(16'hB003);
    for (int n = 0; n < 5; n++) tick();
    chk("stall_pre_valid", 32'(bus_if.o_valid), 32'(1));
    chk("stall_pre_data", 32'(bus_if.o_data), 32'(16'hB001));
    i_en = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("stall%0d_valid", n), 32'(bus_if.o_valid), 32'(1));
      chk($sformatf("stall%0d_data", n), 32'(bus_if.o_data), 32'(16'hB001));
    end
    i_en = 1'b1;
    tick();
    chk("stall_b2_valid", 32'(bus_if.o_valid), 32'(1));
    chk("stall_b2_data", 32'(bus_if.o_data), 32'(16'hB002));
    tick();
    chk("stall_b3_valid", 32'(bus_if.o_valid), 32'(1));
    chk("stall_b3_data", 32'(bus_if.o_data), 32'(16'hB003));
    tick();
    chk("stall_after_valid", 32'(bus_if.o_valid), 32'(0));

    // Flush with words in flight: busy drops on the next edge and nothing exits.
    send(16'hC001);
    send(16'hC002);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_busy", 32'(o_busy), 32'(0));
    chk("flush_valid", 32'(bus_if.o_valid), 32'(0));
    for (int n = 0; n < 8; n++) begin
      tick();
      chk($sformatf("flush_quiet%0d", n), 32'(bus_if.o_valid), 32'(0));
    end

    // Flush plus same-edge capture: the captured word survives and the tap stays put.
    send(16'hC003);
    i_delay        = 8'd2;
    i_flush        = 1'b1;
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = 16'hD001;
    tick();
    i_flush        = 1'b0;
    bus_if.i_valid = 1'b0;
    cap_cyc        = cyc;
    chk("flushcap_delay", 32'(o_delay), 32'(7));
    chk("flushcap_busy", 32'(o_busy), 32'(1));
    for (int n = 0; n < 40 && !bus_if.o_valid; n++) tick();
    chk("flushcap_latency", 32'(cyc - cap_cyc), 32'(7));
    chk("flushcap_data", 32'(bus_if.o_data), 32'(16'hD001));

    // LFSR mode: zero seed becomes 1, then idle reloads walk the sequence clamped to 15.
    wait_idle();
    i_en        = 1'b0;
    i_seed_load = 1'b1;
    i_seed      = 16'h0000;
    tick();
    i_seed_load = 1'b0;
    lfsr_peek   = dut.u_lfsr.value_q;
    chk("seed_zero", 32'(lfsr_peek), 32'(16'h0001));
    i_en   = 1'b1;
    i_mode = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk($sformatf("lfsr_tap%0d", j), 32'(o_delay), 32'(lfsr_exp[j]));
    end

    // Reset mid-operation discards in-flight data and restores the LFSR.
    send(16'hE001);
    send(16'hE002);
    send(16'hE003);
    rst_x = 1'b0;
    tick();
    lfsr_peek = dut.u_lfsr.value_q;
    chk("rst_delay", 32'(o_delay), 32'(0));
    chk("rst_valid", 32'(bus_if.o_valid), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_data", 32'(bus_if.o_data), 32'(0));
    chk("rst_lfsr", 32'(lfsr_peek), 32'(16'hACE1));
    rst_x = 1'b1;
    tick();
    chk("rst_first_lfsr_tap", 32'(o_delay), 32'(15));

    // Random traffic against the queue model.
    for (int n = 0; n < 2500; n++) begin
      rst_x          = ($urandom_range(0, 299) != 0);
      i_en           = ($urandom_range(0, 99) < 85);
      i_flush        = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) i_mode = ~i_mode;
      i_delay        = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      i_seed_load    = ($urandom_range(0, 39) == 0);
      i_seed         = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      bus_if.i_valid = 1'($urandom_range(0, 1));
      bus_if.i_data  = DW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
